// File: rtl/joy_db15_responder_if.sv
// Host-side DB15 joystick link: latch strobe and shift clock from the host,
// serial button data back from the device.
interface joy_db15_responder_if;
    logic joy_load;
    logic joy_clk;
    logic joy_data;

    modport master (
        output joy_load,
        output joy_clk,
        input  joy_data
    );

    modport slave (
        input  joy_load,
        input  joy_clk,
        output joy_data
    );
endinterface

// File: rtl/joy_db15_responder.sv
// Device-side emulation of the DB15 adapter's parallel-in/serial-out chain:
// latches both players' buttons on joy_load and shifts them out on joy_clk.
module joy_db15_responder #(
    parameter int PWIDTH = 16,
    parameter bit FILL   = 1'b1,
    parameter int SYNC   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PWIDTH-1:0] joystick1,
    input  logic [PWIDTH-1:0] joystick2,
    joy_db15_responder_if.slave host,
    output logic              frame_done,
    output logic              overrun
);
    localparam int FRAME = 2 * PWIDTH;
    localparam int CW    = $clog2(FRAME + 1);

    logic [SYNC-1:0]  load_sync;
    logic [SYNC-1:0]  clk_sync;
    logic             load_prev;
    logic             clk_prev;
    logic [FRAME-1:0] shift_reg;
    logic [FRAME-1:0] shift_next;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_next;
    logic             load_s;
    logic             clk_s;
    logic             load_fall;
    logic             clk_rise;
    logic             done_next;
    logic             overrun_next;

    assign load_s    = load_sync[SYNC-1];
    assign clk_s     = clk_sync[SYNC-1];
    assign load_fall = load_prev & ~load_s;
    assign clk_rise  = ~clk_prev & clk_s;

    // Synchronizers preset high so releasing reset never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_sync <= '1;
            clk_sync  <= '1;
            load_prev <= 1'b1;
            clk_prev  <= 1'b1;
        end else begin
            load_sync <= {load_sync[SYNC-2:0], host.joy_load};
            clk_sync  <= {clk_sync[SYNC-2:0], host.joy_clk};
            load_prev <= load_s;
            clk_prev  <= clk_s;
        end
    end

    // Load is transparent and takes priority over any coincident shift edge.
    always_comb begin
        shift_next   = shift_reg;
        cnt_next     = bit_cnt;
        done_next    = 1'b0;
        overrun_next = overrun;
        if (!load_s) begin
            shift_next = ~{joystick2, joystick1};
            cnt_next   = '0;
            if (load_fall) begin
                overrun_next = 1'b0;
            end
        end else if (clk_rise) begin
            shift_next = {FILL, shift_reg[FRAME-1:1]};
            if (bit_cnt == CW'(FRAME)) begin
                overrun_next = 1'b1;
            end else begin
                cnt_next  = bit_cnt + 1'b1;
                done_next = (bit_cnt == CW'(FRAME - 1));
            end
        end
    end

    // joy_data follows the next LSB so the host sees its edge within SYNC+1 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg     <= '1;
            bit_cnt       <= '0;
            host.joy_data <= 1'b1;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            shift_reg     <= shift_next;
            bit_cnt       <= cnt_next;
            host.joy_data <= shift_next[0];
            frame_done    <= done_next;
            overrun       <= overrun_next;
        end
    end
endmodule
